top_stim_checker: RTL and testbench

- Self-checking stimulus block for the `top` interface; the other end of that interface.
- Drives `top`'s A/B inputs and reads back its Q output.
- Cycles through all four A/B input combinations a programmable number of passes, compares Q against the expected A|B and counts mismatches.
- Used as a built-in self-test beside `top` and as the reusable stimulus source in the bench.

---
 rtl/top_stim_checker.sv | 133 +++++++++++++
 tb/tb_top_stim_checker.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/top_stim_checker.sv
// Built-in self-test driver for the OR-gate block `top`: walks A/B through all
// four combinations, checks Q against A|B and keeps a saturating error count.
module top_stim_checker #(
    parameter int N    = 4,
    parameter int HOLD = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] repeats,
    output logic         A,
    output logic         B,
    input  logic         Q,
    output logic         busy,
    output logic         done,
    output logic         pass,
    output logic [N-1:0] err_cnt,
    output logic [1:0]   vec_idx
);

    typedef enum logic [1:0] {IDLE, DRIVE, FINISH} state_t;

    localparam int            HW        = (HOLD > 1) ? $clog2(HOLD) : 1;
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD - 1);
    localparam logic [N-1:0]  ERR_MAX   = '1;

    state_t         state, state_n;
    logic [HW-1:0]  hold_cnt, hold_n;
    logic [N-1:0]   left_cnt, left_n;
    logic [N-1:0]   err_n, err_sampled;
    logic [1:0]     vec_n;
    logic           a_n, b_n, busy_n, done_n, pass_n;
    logic           mismatch;

    assign mismatch = (Q != (A | B));

    // Every output is computed one cycle ahead here so the ports are plain flops.
    always_comb begin
        state_n     = state;
        hold_n      = hold_cnt;
        left_n      = left_cnt;
        err_n       = err_cnt;
        pass_n      = pass;
        err_sampled = err_cnt;
        a_n         = 1'b0;
        b_n         = 1'b0;
        busy_n      = 1'b0;
        done_n      = 1'b0;
        vec_n       = 2'd0;
        case (state)
            IDLE: begin
                if (start) begin
                    left_n = repeats;
                    err_n  = '0;
                    pass_n = 1'b0;
                    hold_n = '0;
                    if (repeats == '0) begin
                        state_n = FINISH;
                        done_n  = 1'b1;
                        pass_n  = 1'b1;
                    end else begin
                        state_n = DRIVE;
                        busy_n  = 1'b1;
                    end
                end
            end
            DRIVE: begin
                busy_n = 1'b1;
                vec_n  = vec_idx;
                a_n    = A;
                b_n    = B;
                if (hold_cnt != HOLD_LAST) begin
                    hold_n = HW'(hold_cnt + 1'b1);
                end else begin
                    hold_n = '0;
                    if (mismatch && err_cnt != ERR_MAX)
                        err_sampled = err_cnt + 1'b1;
                    err_n = err_sampled;
                    if (vec_idx == 2'd3) begin
                        left_n = left_cnt - 1'b1;
                        vec_n  = 2'd0;
                        a_n    = 1'b0;
                        b_n    = 1'b0;
                        // The final sample must already count towards pass.
                        if (left_cnt == 1) begin
                            state_n = FINISH;
                            busy_n  = 1'b0;
                            done_n  = 1'b1;
                            pass_n  = (err_sampled == '0);
                        end
                    end else begin
                        vec_n = vec_idx + 2'd1;
                        a_n   = vec_n[1];
                        b_n   = vec_n[0];
                    end
                end
            end
            FINISH: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= IDLE;
            hold_cnt <= '0;
            left_cnt <= '0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            A        <= 1'b0;
            B        <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            vec_idx  <= 2'd0;
        end else begin
            state    <= state_n;
            hold_cnt <= hold_n;
            left_cnt <= left_n;
            err_cnt  <= err_n;
            pass     <= pass_n;
            A        <= a_n;
            B        <= b_n;
            busy     <= busy_n;
            done     <= done_n;
            vec_idx  <= vec_n;
        end
    end

endmodule

// File: tb/tb_top_stim_checker.sv
// Directed bench for top_stim_checker: two instances (HOLD=2 and HOLD=1) each
// wired to a behavioural `top` whose Q function is selectable.
module tb_top_stim_checker;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start1 = 1'b0, start2 = 1'b0;
    logic [3:0] repeats = 4'd0;
    int         mode = 0;
    int         sel = 2;
    int         testCount = 0;
    int         failCount = 0;

    logic       a1, b1, q1, busy1, done1, pass1;
    logic       a2, b2, q2, busy2, done2, pass2;
    logic [3:0] err1, err2;
    logic [1:0] vec1, vec2;
    logic [10:0] obs;

    always #5 clk = ~clk;

    // Behavioural `top`: 0 good OR, 1 AND fault, 2 NOR fault, else stuck-at-1.
    function automatic logic qmodel(input int m, input logic a, input logic b);
        case (m)
            0:       return a | b;
            1:       return a & b;
            2:       return ~(a | b);
            default: return 1'b1;
        endcase
    endfunction

    assign q1 = qmodel(mode, a1, b1);
    assign q2 = qmodel(mode, a2, b2);

    top_stim_checker #(.N(4), .HOLD(1)) dut1 (
        .clk(clk), .rst(rst), .start(start1), .repeats(repeats),
        .A(a1), .B(b1), .Q(q1), .busy(busy1), .done(done1), .pass(pass1),
        .err_cnt(err1), .vec_idx(vec1)
    );

    top_stim_checker #(.N(4), .HOLD(2)) dut2 (
        .clk(clk), .rst(rst), .start(start2), .repeats(repeats),
        .A(a2), .B(b2), .Q(q2), .busy(busy2), .done(done2), .pass(pass2),
        .err_cnt(err2), .vec_idx(vec2)
    );

    always_comb begin
        obs = (sel == 1) ? {busy1, done1, pass1, err1, vec1, a1, b1}
                         : {busy2, done2, pass2, err2, vec2, a2, b2};
    end

    function automatic logic [10:0] pk(input bit bsy, input bit dn, input bit ps,
                                       input int err, input int vec, input bit a, input bit b);
        return {bsy, dn, ps, 4'(err), 2'(vec), a, b};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] expv);
        testCount++;
        if (got !== expv) begin
            failCount++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    task automatic setStart(input int which, input bit v);
        if (which == 1) start1 = v;
        else            start2 = v;
    endtask

    // Starts a run and checks every busy cycle, then the done cycle and the idle after it.
    task automatic applyStimulus(input string tag, input int which, input int reps, input int hold,
                                 input int expErr, input bit expPass, input int poke);
        int n;
        int v;
        sel     = which;
        repeats = 4'(reps);
        setStart(which, 1'b1);
        step();
        setStart(which, 1'b0);
        n = 4 * hold * reps;
        for (int k = 0; k < n; k++) begin
            v = (k / hold) % 4;
            checkOutput({tag, "_drive"}, 32'(obs[10:9]) << 4 | 32'(obs[3:0]),
                        32'(2'b10) << 4 | 32'({v[1:0], v[1], v[0]}));
            if (k == poke) begin
                setStart(which, 1'b1);
                repeats = 4'd0;
            end
            if (k == poke + 1) setStart(which, 1'b0);
            step();
        end
        checkOutput({tag, "_done"}, 32'(obs), 32'(pk(0, 1, expPass, expErr, 0, 0, 0)));
        step();
        checkOutput({tag, "_idle"}, 32'(obs), 32'(pk(0, 0, expPass, expErr, 0, 0, 0)));
    endtask

    initial begin
        // Reset held with start and a stuck-high Q must not start anything.
        sel = 2; mode = 3; rst = 1'b0; start2 = 1'b1; start1 = 1'b1; repeats = 4'd3;
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("reset_hold", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
        end
        start1 = 1'b0; start2 = 1'b0; rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            checkOutput("reset_release", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
        end

        mode = 0;
        applyStimulus("good_h2_r2", 2, 2, 2, 0, 1'b1, -10);

        mode = 1;
        applyStimulus("and_h1_r1", 1, 1, 1, 2, 1'b0, -10);

        mode = 2;
        applyStimulus("sat_h2_r5", 2, 5, 2, 15, 1'b0, -10);

        mode = 0;
        applyStimulus("zero_reps", 2, 0, 2, 0, 1'b1, -10);

        applyStimulus("restart_ignored", 2, 2, 2, 0, 1'b1, 3);

        // Abort during vector 2 of the first pass with errors already counted.
        mode = 2; sel = 2; repeats = 4'd2;
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 0; k < 4; k++) step();
        checkOutput("abort_pre", 32'(obs), 32'(pk(1, 0, 0, 2, 2, 1, 0)));
        rst = 1'b0;
        step();
        checkOutput("abort_reset", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
        rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            checkOutput("abort_quiet", 32'(obs), 32'(pk(0, 0, 0, 0, 0, 0, 0)));
        end

        mode = 0;
        applyStimulus("fresh_run", 2, 1, 2, 0, 1'b1, -10);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
